// File: rtl/usr_pkg.sv
// usr_pkg: shared types and helpers for the universal shift register.
//   usr_mode_t  - 3-bit operating mode (HOLD, LOAD, SHR, SHL, ROR, ROL, ASR, reserved)
//   usr_state_t - burst controller states (IDLE, RUN, DONE)
//   usr_cnt_w   - default burst-count width for a given register width
//   usr_is_burst_mode - modes that a start pulse turns into a burst
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_SHL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_ROL  = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_RSVD = 3'd7
    } usr_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } usr_state_t;

    // Room for bursts longer than the register itself.
    function automatic int unsigned usr_cnt_w(input int unsigned width);
        return $clog2(width) + 2;
    endfunction

    function automatic logic usr_is_burst_mode(input usr_mode_t m);
        case (m)
            MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usr_step.sv
// usr_step: combinational next-value unit, shared by direct and burst paths.
//   r           - current register value
//   mode        - step to apply
//   parallel_in - LOAD data
//   serial_in_l - bit entering the MSB on SHR
//   serial_in_r - bit entering the LSB on SHL
//   nxt         - value after one step
module usr_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] r,
    input  usr_mode_t        mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_l,
    input  logic             serial_in_r,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = r;
        case (mode)
            MODE_LOAD: nxt = parallel_in;
            MODE_SHR:  nxt = {serial_in_l, r[WIDTH-1:1]};
            MODE_SHL:  nxt = {r[WIDTH-2:0], serial_in_r};
            MODE_ROR:  nxt = {r[0], r[WIDTH-1:1]};
            MODE_ROL:  nxt = {r[WIDTH-2:0], r[WIDTH-1]};
            MODE_ASR:  nxt = {r[WIDTH-1], r[WIDTH-1:1]};
            default:   nxt = r;
        endcase
    end

endmodule

// File: rtl/univ_shift_register.sv
// univ_shift_register: parametrised universal shift register with burst controller.
//   clk, rst              - clock, synchronous active-high reset
//   mode                  - 0 HOLD,1 LOAD,2 SHR,3 SHL,4 ROR,5 ROL,6 ASR,7 HOLD
//   parallel_in           - LOAD data
//   serial_in_l/_r        - serial bits entering MSB (SHR) / LSB (SHL)
//   start, shift_cnt      - request a burst of shift_cnt steps of mode
//   parallel_out          - register contents
//   serial_out_l/_r       - MSB / LSB of the register
//   busy, done            - burst running / one-cycle completion pulse
module univ_shift_register
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = usr_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_l,
    input  logic             serial_in_r,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_l,
    output logic             serial_out_r,
    output logic             busy,
    output logic             done
);

    usr_state_t       state_q, state_nxt;
    usr_mode_t        mode_q;
    usr_mode_t        live_mode;
    usr_mode_t        step_mode;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] step_nxt;
    logic             start_burst;

    assign live_mode   = usr_mode_t'(mode);
    assign start_burst = (state_q == ST_IDLE) && start && usr_is_burst_mode(live_mode);
    // During a burst the latched mode drives the step unit; live mode is ignored.
    assign step_mode   = (state_q == ST_RUN) ? mode_q : live_mode;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .r           (r_q),
        .mode        (step_mode),
        .parallel_in (parallel_in),
        .serial_in_l (serial_in_l),
        .serial_in_r (serial_in_r),
        .nxt         (step_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (start_burst) state_nxt = (shift_cnt == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt_q == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Datapath: register, burst counter, latched mode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_HOLD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Accepting a burst leaves the register untouched on that edge.
                    if (start_burst) begin
                        mode_q <= live_mode;
                        cnt_q  <= shift_cnt;
                    end else begin
                        r_q <= step_nxt;
                    end
                end
                ST_RUN: begin
                    r_q   <= step_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign parallel_out = r_q;
    assign serial_out_l = r_q[WIDTH-1];
    assign serial_out_r = r_q[0];

endmodule

// File: tb/tb_univ_shift_register.sv
// Self-checking bench for univ_shift_register (WIDTH=4, CNT_W=4).
module tb_univ_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic [3:0] parallel_in;
    logic       serial_in_l;
    logic       serial_in_r;
    logic       start;
    logic [3:0] shift_cnt;
    logic [3:0] parallel_out;
    logic       serial_out_l;
    logic       serial_out_r;
    logic       busy;
    logic       done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHR = 3'd2, SHL = 3'd3,
                           ROR = 3'd4, ROL = 3'd5, ASR = 3'd6, RSV = 3'd7;

    univ_shift_register #(.WIDTH(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .parallel_in  (parallel_in),
        .serial_in_l  (serial_in_l),
        .serial_in_r  (serial_in_r),
        .start        (start),
        .shift_cnt    (shift_cnt),
        .parallel_out (parallel_out),
        .serial_out_l (serial_out_l),
        .serial_out_r (serial_out_r),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] mode;
        logic [3:0] pin;
        logic       sil;
        logic       sir;
        logic       start;
        logic [3:0] cnt;
        logic [3:0] exp_po;
        logic       exp_busy;
        logic       exp_done;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] po;
        logic       busy;
        logic       done;
        string      name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst         = v.rst;
        mode        = v.mode;
        parallel_in = v.pin;
        serial_in_l = v.sil;
        serial_in_r = v.sir;
        start       = v.start;
        shift_cnt   = v.cnt;
        sb.push_back('{po: v.exp_po, busy: v.exp_busy, done: v.exp_done, name: v.name});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb.pop_front();
            check({e.name, ".po"},   parallel_out,        e.po);
            check({e.name, ".sol"},  {3'b0, serial_out_l}, {3'b0, e.po[3]});
            check({e.name, ".sor"},  {3'b0, serial_out_r}, {3'b0, e.po[0]});
            check({e.name, ".busy"}, {3'b0, busy},         {3'b0, e.busy});
            check({e.name, ".done"}, {3'b0, done},         {3'b0, e.done});
        end
    endtask

    task automatic step(input logic r, input logic [2:0] m, input logic [3:0] p,
                        input logic sl, input logic sr, input logic st, input logic [3:0] c,
                        input logic [3:0] epo, input logic eb, input logic ed, input string nm);
        vec_t v;
        v = '{rst: r, mode: m, pin: p, sil: sl, sir: sr, start: st, cnt: c,
              exp_po: epo, exp_busy: eb, exp_done: ed, name: nm};
        apply(v);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; mode = HOLD; parallel_in = '0; serial_in_l = 1'b0;
        serial_in_r = 1'b0; start = 1'b0; shift_cnt = '0;

        // Reset held two cycles with random inputs
        for (int i = 0; i < 2; i++)
            step(1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 4'($urandom), 4'b0000, 1'b0, 1'b0, "reset");

        //            rst   mode  pin      sil   sir   start cnt    po       busy  done  name
        tbl.push_back('{1'b0, LOAD, 4'b1101, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1101, 1'b0, 1'b0, "load"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0, 4'b1101, 1'b0, 1'b0, "hold1"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0, 4'b1101, 1'b0, 1'b0, "hold2"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0, 4'b1101, 1'b0, 1'b0, "hold3"});
        tbl.push_back('{1'b0, SHR,  4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 4'b0110, 1'b0, 1'b0, "shr"});
        tbl.push_back('{1'b0, SHL,  4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 4'b1101, 1'b0, 1'b0, "shl"});
        tbl.push_back('{1'b0, RSV,  4'b0000, 1'b1, 1'b1, 1'b0, 4'd0, 4'b1101, 1'b0, 1'b0, "mode7"});
        // ROR burst of 3; live mode toggled to LOAD mid-burst
        tbl.push_back('{1'b0, ROR,  4'b0000, 1'b0, 1'b0, 1'b1, 4'd3, 4'b1101, 1'b1, 1'b0, "ror_e0"});
        tbl.push_back('{1'b0, LOAD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1110, 1'b1, 1'b0, "ror_e1"});
        tbl.push_back('{1'b0, LOAD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0111, 1'b1, 1'b0, "ror_e2"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1011, 1'b0, 1'b1, "ror_e3"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1011, 1'b0, 1'b0, "ror_idle"});
        // ASR burst of 2, then zero-count burst
        tbl.push_back('{1'b0, LOAD, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1000, 1'b0, 1'b0, "asr_load"});
        tbl.push_back('{1'b0, ASR,  4'b0000, 1'b0, 1'b0, 1'b1, 4'd2, 4'b1000, 1'b1, 1'b0, "asr_e0"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1100, 1'b1, 1'b0, "asr_e1"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1110, 1'b0, 1'b1, "asr_e2"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1110, 1'b0, 1'b0, "asr_idle"});
        tbl.push_back('{1'b0, ASR,  4'b0000, 1'b0, 1'b0, 1'b1, 4'd0, 4'b1110, 1'b0, 1'b1, "cnt0_e0"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1110, 1'b0, 1'b0, "cnt0_idle"});
        // Long rotate: ROL 5 on 0001 wraps past the width
        tbl.push_back('{1'b0, LOAD, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b0, "rol_load"});
        tbl.push_back('{1'b0, ROL,  4'b0000, 1'b0, 1'b0, 1'b1, 4'd5, 4'b0001, 1'b1, 1'b0, "rol_e0"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0010, 1'b1, 1'b0, "rol_e1"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0100, 1'b1, 1'b0, "rol_e2"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1000, 1'b1, 1'b0, "rol_e3"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, "rol_e4"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0010, 1'b0, 1'b1, "rol_e5"});
        tbl.push_back('{1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0010, 1'b0, 1'b0, "rol_idle"});
        // Direct SHR with a one entering, and ASR on a negative value
        tbl.push_back('{1'b0, SHR,  4'b0000, 1'b1, 1'b0, 1'b0, 4'd0, 4'b1001, 1'b0, 1'b0, "shr_one"});
        tbl.push_back('{1'b0, ASR,  4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1100, 1'b0, 1'b0, "asr_direct"});

        foreach (tbl[i]) apply(tbl[i]);

        // start during RUN and DONE is ignored; serial input sampled live in RUN
        step(1'b0, LOAD, 4'b0101, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0101, 1'b0, 1'b0, "ign_load");
        step(1'b0, SHL,  4'b0000, 1'b0, 1'b0, 1'b1, 4'd2, 4'b0101, 1'b1, 1'b0, "ign_e0");
        step(1'b0, SHR,  4'b0000, 1'b0, 1'b1, 1'b1, 4'd3, 4'b1011, 1'b1, 1'b0, "ign_run_start");
        step(1'b0, ROR,  4'b0000, 1'b0, 1'b0, 1'b1, 4'd1, 4'b0110, 1'b0, 1'b1, "ign_e2");
        step(1'b0, ROR,  4'b0000, 1'b0, 1'b0, 1'b1, 4'd1, 4'b0110, 1'b0, 1'b0, "ign_done_start");
        step(1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0110, 1'b0, 1'b0, "ign_idle");

        // start with LOAD is a plain load
        step(1'b0, LOAD, 4'b1001, 1'b0, 1'b0, 1'b1, 4'd2, 4'b1001, 1'b0, 1'b0, "start_load");
        step(1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1001, 1'b0, 1'b0, "start_load_after");

        // Reset mid-burst: R=0111 with 2 steps left
        step(1'b0, LOAD, 4'b1110, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1110, 1'b0, 1'b0, "rst_load");
        step(1'b0, ROR,  4'b0000, 1'b0, 1'b0, 1'b1, 4'd3, 4'b1110, 1'b1, 1'b0, "rst_e0");
        step(1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0111, 1'b1, 1'b0, "rst_e1");
        step(1'b1, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, "rst_mid");
        step(1'b0, HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, "rst_after");
        step(1'b0, LOAD, 4'b1010, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1010, 1'b0, 1'b0, "rst_idle_load");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1);
    end

endmodule
